// File: rtl/net_packet_buffer.sv
// Store-and-forward packet buffer: whole packets only, drops packets that do not fit.
// Optional per-flit byte keep is enabled with NET_PKT_BUFFER_KEEP_EN.
module net_packet_buffer #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 64,
    parameter int MAX_PKTS = 8,
    parameter int CNT_W    = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_bits_data,
    input  logic                        in_bits_last,
`ifdef NET_PKT_BUFFER_KEEP_EN
    input  logic [DATA_W/8-1:0]         in_bits_keep,
    output logic [DATA_W/8-1:0]         out_bits_keep,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_bits_data,
    output logic                        out_bits_last,
    output logic [$clog2(MAX_PKTS):0]   pkt_count,
    output logic [CNT_W-1:0]            drop_count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int PCW = $clog2(MAX_PKTS) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_in_ready;
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      r_pkt_start;
    logic [PCW-1:0]     r_pkt_count;
    logic [CNT_W-1:0]   r_drop_count;
    logic [DATA_W-1:0]  r_mem  [DEPTH];
    logic               r_last [DEPTH];
`ifdef NET_PKT_BUFFER_KEEP_EN
    logic [DATA_W/8-1:0] r_keep [DEPTH];
`endif

    logic          w_accept;
    logic [PW-1:0] w_used;
    logic          w_full;
    logic          w_pkts_full;
    logic          w_wr_en;
    logic          w_commit;
    logic          w_drop;
    logic          w_rd;
    logic          w_rd_last;

    assign w_accept    = in_valid & r_in_ready;
    assign w_used      = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_used == PW'(DEPTH));
    assign w_pkts_full = (r_pkt_count == PCW'(MAX_PKTS));

    assign out_valid     = (r_pkt_count != '0);
    assign out_bits_data = r_mem[r_rd_ptr[AW-1:0]];
    assign out_bits_last = r_last[r_rd_ptr[AW-1:0]];
`ifdef NET_PKT_BUFFER_KEEP_EN
    assign out_bits_keep = r_keep[r_rd_ptr[AW-1:0]];
`endif
    assign in_ready      = r_in_ready;
    assign pkt_count     = r_pkt_count;
    assign drop_count    = r_drop_count;

    assign w_rd      = out_valid & out_ready;
    assign w_rd_last = w_rd & out_bits_last;

    // A last flit with no packet slot left is dropped even if storage has room.
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_commit     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_IDLE, S_RECV: begin
                if (w_accept) begin
                    if (!w_full && (!in_bits_last || !w_pkts_full)) begin
                        w_wr_en = 1'b1;
                        if (in_bits_last) begin
                            w_commit     = 1'b1;
                            w_next_state = S_IDLE;
                        end else begin
                            w_next_state = S_RECV;
                        end
                    end else begin
                        w_drop       = 1'b1;
                        w_next_state = in_bits_last ? S_IDLE : S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (w_accept && in_bits_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pkt_start  <= '0;
            r_pkt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= 1'b1;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end else if (w_drop) begin
                r_wr_ptr <= r_pkt_start;
            end
            if (w_commit) begin
                r_pkt_start <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Commit and last-flit read in one cycle cancel out.
            case ({w_commit, w_rd_last})
                2'b10:   r_pkt_count <= r_pkt_count + 1'b1;
                2'b01:   r_pkt_count <= r_pkt_count - 1'b1;
                default: r_pkt_count <= r_pkt_count;
            endcase
            if (w_drop && (r_drop_count != {CNT_W{1'b1}})) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    // Storage is cleared on reset so the output payload reads zero out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i]  <= '0;
                r_last[i] <= 1'b0;
`ifdef NET_PKT_BUFFER_KEEP_EN
                r_keep[i] <= '0;
`endif
            end
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]]  <= in_bits_data;
            r_last[r_wr_ptr[AW-1:0]] <= in_bits_last;
`ifdef NET_PKT_BUFFER_KEEP_EN
            r_keep[r_wr_ptr[AW-1:0]] <= in_bits_keep;
`endif
        end
    end

endmodule

// File: tb/tb_net_packet_buffer.sv
// Directed bench for net_packet_buffer: one default-sized instance and one
// small instance (DEPTH=4, MAX_PKTS=2, CNT_W=2) sharing clock and reset.
module tb_net_packet_buffer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [63:0] b_in_data  = '0;
    logic        b_in_last  = 1'b0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [63:0] b_out_data;
    logic        b_out_last;
    logic [3:0]  b_pkt_count;
    logic [31:0] b_drop_count;
`ifdef NET_PKT_BUFFER_KEEP_EN
    logic [7:0]  b_in_keep = '0;
    logic [7:0]  b_out_keep;
    logic [1:0]  s_in_keep = '0;
    logic [1:0]  s_out_keep;
`endif

    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [15:0] s_in_data  = '0;
    logic        s_in_last  = 1'b0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b0;
    logic [15:0] s_out_data;
    logic        s_out_last;
    logic [1:0]  s_pkt_count;
    logic [1:0]  s_drop_count;

    net_packet_buffer u_big (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_bits_data(b_in_data), .in_bits_last(b_in_last),
`ifdef NET_PKT_BUFFER_KEEP_EN
        .in_bits_keep(b_in_keep), .out_bits_keep(b_out_keep),
`endif
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_bits_data(b_out_data), .out_bits_last(b_out_last),
        .pkt_count(b_pkt_count), .drop_count(b_drop_count)
    );

    net_packet_buffer #(.DATA_W(16), .DEPTH(4), .MAX_PKTS(2), .CNT_W(2)) u_small (
        .clock(clock), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_bits_data(s_in_data), .in_bits_last(s_in_last),
`ifdef NET_PKT_BUFFER_KEEP_EN
        .in_bits_keep(s_in_keep), .out_bits_keep(s_out_keep),
`endif
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_bits_data(s_out_data), .out_bits_last(s_out_last),
        .pkt_count(s_pkt_count), .drop_count(s_drop_count)
    );

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic b_flit(input logic [63:0] data, input logic last);
        b_in_valid = 1'b1; b_in_data = data; b_in_last = last;
        step();
        b_in_valid = 1'b0;
    endtask

    task automatic s_flit(input logic [15:0] data, input logic last);
        s_in_valid = 1'b1; s_in_data = data; s_in_last = last;
        step();
        s_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests_run++; if (b_in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready got %0b want 0", b_in_ready); end
        tests_run++; if (b_out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid got %0b want 0", b_out_valid); end
        tests_run++; if (b_out_data !== 64'h0) begin tests_failed++; $display("FAIL rst_out_data got %h want 0", b_out_data); end
        tests_run++; if (b_pkt_count !== 4'd0) begin tests_failed++; $display("FAIL rst_pkt_count got %0d want 0", b_pkt_count); end
        tests_run++; if (b_drop_count !== 32'd0) begin tests_failed++; $display("FAIL rst_drop_count got %0d want 0", b_drop_count); end
        step();
        reset = 1'b0;
        tests_run++; if (b_in_ready !== 1'b0) begin tests_failed++; $display("FAIL rel_in_ready_early got %0b want 0", b_in_ready); end
        step();
        tests_run++; if (b_in_ready !== 1'b1) begin tests_failed++; $display("FAIL rel_in_ready got %0b want 1", b_in_ready); end
        tests_run++; if (s_in_ready !== 1'b1) begin tests_failed++; $display("FAIL rel_s_in_ready got %0b want 1", s_in_ready); end
    endtask

    task automatic test_basic();
        logic [63:0] exp_d [3];
        exp_d[0] = 64'h11; exp_d[1] = 64'h22; exp_d[2] = 64'h33;
        b_out_ready = 1'b0;
        b_flit(64'h11, 1'b0);
        tests_run++; if (b_out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_hold1 out_valid got %0b want 0", b_out_valid); end
        b_flit(64'h22, 1'b0);
        tests_run++; if (b_out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_hold2 out_valid got %0b want 0", b_out_valid); end
        b_flit(64'h33, 1'b1);
        tests_run++; if (b_out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_commit out_valid got %0b want 1", b_out_valid); end
        tests_run++; if (b_pkt_count !== 4'd1) begin tests_failed++; $display("FAIL basic_pkt_count got %0d want 1", b_pkt_count); end
        tests_run++; if (b_out_data !== 64'h11) begin tests_failed++; $display("FAIL basic_head got %h want 11", b_out_data); end
        step();
        tests_run++; if (b_out_data !== 64'h11) begin tests_failed++; $display("FAIL basic_stable got %h want 11", b_out_data); end
        b_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++; if (b_out_data !== exp_d[i] || b_out_last !== (i == 2)) begin
                tests_failed++; $display("FAIL basic_read%0d got %h/%0b want %h/%0b", i, b_out_data, b_out_last, exp_d[i], (i == 2)); end
            step();
        end
        tests_run++; if (b_pkt_count !== 4'd0 || b_out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_drained pkt_count %0d valid %0b want 0 0", b_pkt_count, b_out_valid); end
        b_out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        b_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b_flit(64'hA0 + 64'(i), 1'b1);
            tests_run++; if (b_pkt_count !== 4'd1 || b_out_data !== 64'hA0 + 64'(i) || b_out_last !== 1'b1) begin
                tests_failed++; $display("FAIL b2b_%0d count %0d data %h last %0b want 1 %h 1", i, b_pkt_count, b_out_data, b_out_last, 64'hA0 + 64'(i)); end
        end
        step();
        tests_run++; if (b_pkt_count !== 4'd0) begin tests_failed++; $display("FAIL b2b_drain pkt_count got %0d want 0", b_pkt_count); end
        tests_run++; if (b_drop_count !== 32'd0) begin tests_failed++; $display("FAIL b2b_drops got %0d want 0", b_drop_count); end
        b_out_ready = 1'b0;
    endtask

    task automatic test_overflow_depth();
        s_out_ready = 1'b0;
        s_flit(16'hA0, 1'b0);
        s_flit(16'hA1, 1'b1);
        s_flit(16'hB0, 1'b0);
        s_flit(16'hB1, 1'b0);
        tests_run++; if (s_drop_count !== 2'd0) begin tests_failed++; $display("FAIL ovf_nodrop_yet got %0d want 0", s_drop_count); end
        s_flit(16'hB2, 1'b0);
        tests_run++; if (s_drop_count !== 2'd1) begin tests_failed++; $display("FAIL ovf_drop got %0d want 1", s_drop_count); end
        tests_run++; if (u_small.r_wr_ptr !== 3'd2) begin tests_failed++; $display("FAIL ovf_rewind wr_ptr got %0d want 2", u_small.r_wr_ptr); end
        s_flit(16'hB3, 1'b1);
        tests_run++; if (s_drop_count !== 2'd1 || s_pkt_count !== 2'd1) begin tests_failed++; $display("FAIL ovf_tail drops %0d pkts %0d want 1 1", s_drop_count, s_pkt_count); end
        s_out_ready = 1'b1;
        #1;
        tests_run++; if (s_out_data !== 16'hA0 || s_out_last !== 1'b0) begin tests_failed++; $display("FAIL ovf_read0 got %h/%0b want a0/0", s_out_data, s_out_last); end
        step();
        tests_run++; if (s_out_data !== 16'hA1 || s_out_last !== 1'b1) begin tests_failed++; $display("FAIL ovf_read1 got %h/%0b want a1/1", s_out_data, s_out_last); end
        step();
        tests_run++; if (s_out_valid !== 1'b0 || s_pkt_count !== 2'd0) begin tests_failed++; $display("FAIL ovf_drained valid %0b pkts %0d want 0 0", s_out_valid, s_pkt_count); end
        s_out_ready = 1'b0;
    endtask

    task automatic test_max_pkts();
        s_flit(16'hC1, 1'b1);
        s_flit(16'hC2, 1'b1);
        s_flit(16'hC3, 1'b1);
        tests_run++; if (s_pkt_count !== 2'd2) begin tests_failed++; $display("FAIL maxp_count got %0d want 2", s_pkt_count); end
        tests_run++; if (s_drop_count !== 2'd2) begin tests_failed++; $display("FAIL maxp_drops got %0d want 2", s_drop_count); end
        tests_run++; if (s_in_ready !== 1'b1) begin tests_failed++; $display("FAIL maxp_in_ready got %0b want 1", s_in_ready); end
        s_flit(16'hC4, 1'b1);
        tests_run++; if (s_drop_count !== 2'd3) begin tests_failed++; $display("FAIL sat_reach got %0d want 3", s_drop_count); end
        s_flit(16'hC5, 1'b1);
        tests_run++; if (s_drop_count !== 2'd3) begin tests_failed++; $display("FAIL sat_hold got %0d want 3", s_drop_count); end
        s_out_ready = 1'b1;
        #1;
        tests_run++; if (s_out_data !== 16'hC1) begin tests_failed++; $display("FAIL maxp_read0 got %h want c1", s_out_data); end
        step();
        tests_run++; if (s_out_data !== 16'hC2 || s_pkt_count !== 2'd1) begin tests_failed++; $display("FAIL maxp_read1 got %h cnt %0d want c2 1", s_out_data, s_pkt_count); end
        step();
        tests_run++; if (s_pkt_count !== 2'd0) begin tests_failed++; $display("FAIL maxp_drained got %0d want 0", s_pkt_count); end
        s_out_ready = 1'b0;
    endtask

`ifdef NET_PKT_BUFFER_KEEP_EN
    task automatic test_keep();
        b_in_keep = 8'hFF; b_flit(64'hD0, 1'b0);
        b_in_keep = 8'h0F; b_flit(64'hD1, 1'b1);
        b_in_keep = 8'h00;
        tests_run++; if (b_out_keep !== 8'hFF || b_out_data !== 64'hD0) begin tests_failed++; $display("FAIL keep0 got %h/%h want ff/d0", b_out_keep, b_out_data); end
        b_out_ready = 1'b1;
        step();
        tests_run++; if (b_out_keep !== 8'h0F || b_out_data !== 64'hD1) begin tests_failed++; $display("FAIL keep1 got %h/%h want 0f/d1", b_out_keep, b_out_data); end
        step();
        b_out_ready = 1'b0;
    endtask
`endif

    task automatic test_mid_reset();
        b_out_ready = 1'b0;
        b_flit(64'h55, 1'b1);
        b_flit(64'h66, 1'b0);
        b_flit(64'h67, 1'b0);
        tests_run++; if (b_out_valid !== 1'b1) begin tests_failed++; $display("FAIL mrst_pre valid got %0b want 1", b_out_valid); end
        reset = 1'b1;
        #1;
        tests_run++; if (b_out_valid !== 1'b0 || b_pkt_count !== 4'd0) begin tests_failed++; $display("FAIL mrst_async valid %0b pkts %0d want 0 0", b_out_valid, b_pkt_count); end
        tests_run++; if (b_out_data !== 64'h0 || b_in_ready !== 1'b0) begin tests_failed++; $display("FAIL mrst_async data %h in_ready %0b want 0 0", b_out_data, b_in_ready); end
        step();
        reset = 1'b0;
        tests_run++; if (b_in_ready !== 1'b0) begin tests_failed++; $display("FAIL mrst_in_ready_early got %0b want 0", b_in_ready); end
        step();
        tests_run++; if (b_in_ready !== 1'b1) begin tests_failed++; $display("FAIL mrst_in_ready got %0b want 1", b_in_ready); end
        b_flit(64'h77, 1'b1);
        tests_run++; if (b_out_valid !== 1'b1 || b_out_data !== 64'h77 || b_pkt_count !== 4'd1) begin
            tests_failed++; $display("FAIL mrst_fresh valid %0b data %h pkts %0d want 1 77 1", b_out_valid, b_out_data, b_pkt_count); end
        b_out_ready = 1'b1;
        step();
        tests_run++; if (b_pkt_count !== 4'd0) begin tests_failed++; $display("FAIL mrst_drain got %0d want 0", b_pkt_count); end
        b_out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow_depth();
        test_max_pkts();
`ifdef NET_PKT_BUFFER_KEEP_EN
        test_keep();
`endif
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
